// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID / uptime slave: word map, CTRL bits, CAPS layout.
package sysid_pkg;

    typedef enum logic [2:0] {
        ADDR_ID     = 3'd0,
        ADDR_TS     = 3'd1,
        ADDR_CAPS   = 3'd2,
        ADDR_SCR    = 3'd3,
        ADDR_UP_LO  = 3'd4,
        ADDR_UP_HI  = 3'd5,
        ADDR_CTRL   = 3'd6,
        ADDR_RSVD   = 3'd7
    } sysid_addr_e;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    localparam int CAPS_PRESCALE_LSB = 16;
    localparam int CAPS_WIDTH_LSB    = 0;

    function automatic logic [31:0] caps_word(input int prescale, input int width);
        logic [31:0] w;
        w = (32'(16'(prescale)) << CAPS_PRESCALE_LSB) | (32'(8'(width)) << CAPS_WIDTH_LSB);
        return w;
    endfunction

endpackage

// File: rtl/sysid_uptime_ctr.sv
// Prescaled free-running uptime counter with enable and synchronous clear.
module sysid_uptime_ctr
    import sysid_pkg::*;
#(
    parameter int UPTIME_W = 64,
    parameter int PRESCALE = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                i_en,
    input  logic                i_clr,
    output logic [UPTIME_W-1:0] o_count
);

    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]       r_pre;
    logic [UPTIME_W-1:0] r_count;
    logic                w_tick;

    assign w_tick  = i_en && (r_pre == PRE_LAST);
    assign o_count = r_count;

    // Clear wins over a tick landing on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pre   <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_pre   <= '0;
            r_count <= '0;
        end else if (w_tick) begin
            r_pre   <= '0;
            r_count <= r_count + 1'b1;
        end else if (i_en) begin
            r_pre   <= r_pre + 1'b1;
        end
    end

endmodule

// File: rtl/sysid_uptime_slave.sv
// Avalon-MM slave: system ID, build timestamp, capabilities, scratch, uptime with HI shadow.
module sysid_uptime_slave
    import sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'd1563155245,
    parameter int          UPTIME_W    = 64,
    parameter int          PRESCALE    = 1,
    parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [31:0] CAPS_VALUE = caps_word(PRESCALE, UPTIME_W);

    logic [UPTIME_W-1:0]  w_count;
    logic [31:0]          w_rd_mux;
    logic                 w_wr_ctrl;
    logic                 w_clr;
    logic                 w_rd_lo;
    logic                 r_en;
    logic [31:0]          r_scratch;
    logic [UPTIME_W-33:0] r_shadow;
    logic [31:0]          r_readdata;
    logic                 r_rdv;

    assign w_wr_ctrl = write && (address == ADDR_CTRL);
    assign w_clr     = w_wr_ctrl && writedata[CTRL_CLR];
    assign w_rd_lo   = read && (address == ADDR_UP_LO);

    sysid_uptime_ctr #(
        .UPTIME_W (UPTIME_W),
        .PRESCALE (PRESCALE)
    ) u_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .i_en    (r_en),
        .i_clr   (w_clr),
        .o_count (w_count)
    );

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_ID:    w_rd_mux = ID_VALUE;
            ADDR_TS:    w_rd_mux = TIMESTAMP;
            ADDR_CAPS:  w_rd_mux = CAPS_VALUE;
            ADDR_SCR:   w_rd_mux = r_scratch;
            ADDR_UP_LO: w_rd_mux = w_count[31:0];
            ADDR_UP_HI: w_rd_mux = 32'(r_shadow);
            ADDR_CTRL:  w_rd_mux[CTRL_EN] = r_en;
            default:    w_rd_mux = '0;
        endcase
    end

    // Reads sample the pre-edge state, so a same-cycle write or tick is not visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
            r_rdv      <= 1'b0;
            r_shadow   <= '0;
        end else begin
            r_rdv <= read;
            if (read) begin
                r_readdata <= w_rd_mux;
            end
            if (w_rd_lo) begin
                r_shadow <= w_count[UPTIME_W-1:32];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scratch <= SCRATCH_RST;
            r_en      <= 1'b1;
        end else begin
            if (write && (address == ADDR_SCR)) begin
                r_scratch <= writedata;
            end
            if (w_wr_ctrl) begin
                r_en <= writedata[CTRL_EN];
            end
        end
    end

    assign readdata      = r_readdata;
    assign readdatavalid = r_rdv;

endmodule

// File: tb/tb_sysid_uptime_slave.sv
// Self-checking bench for sysid_uptime_slave: cycle model plus directed literal checks.
module tb_sysid_uptime_slave;

    localparam logic [31:0] ID_VALUE    = 32'hCAFE_0001;
    localparam logic [31:0] TIMESTAMP   = 32'd1563155245;
    localparam int          UPTIME_W    = 48;
    localparam int          PRESCALE    = 4;
    localparam logic [31:0] SCRATCH_RST = 32'h1357_9BDF;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_on = 1'b0;

    always #5 clock = ~clock;

    sysid_uptime_slave #(
        .ID_VALUE    (ID_VALUE),
        .TIMESTAMP   (TIMESTAMP),
        .UPTIME_W    (UPTIME_W),
        .PRESCALE    (PRESCALE),
        .SCRATCH_RST (SCRATCH_RST)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    // Behavioural model: register file semantics evaluated once per clock edge.
    logic [47:0] m_up;
    int          m_pre;
    logic        m_en;
    logic [31:0] m_scr;
    logic [15:0] m_shadow;
    logic [31:0] m_rd;
    logic        m_rdv;

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return ID_VALUE;
            3'd1:    return TIMESTAMP;
            3'd2:    return {16'd4, 8'd0, 8'd48};
            3'd3:    return m_scr;
            3'd4:    return m_up[31:0];
            3'd5:    return {16'd0, m_shadow};
            3'd6:    return {31'd0, m_en};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_up = '0; m_pre = 0; m_en = 1'b1; m_scr = SCRATCH_RST;
            m_shadow = '0; m_rd = '0; m_rdv = 1'b0;
        end else begin
            logic tick, clr;
            m_rdv = read;
            if (read) begin
                m_rd = model_read(address);
                if (address == 3'd4) m_shadow = m_up[47:32];
            end
            tick = m_en && (m_pre == PRESCALE - 1);
            clr  = write && (address == 3'd6) && writedata[1];
            if (clr) begin
                m_up = '0; m_pre = 0;
            end else if (tick) begin
                m_up = m_up + 48'd1; m_pre = 0;
            end else if (m_en) begin
                m_pre = m_pre + 1;
            end
            if (write && address == 3'd3) m_scr = writedata;
            if (write && address == 3'd6) m_en = writedata[0];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on && reset_n) begin
            chk("cyc_rdv", 64'(readdatavalid), 64'(m_rdv));
            chk("cyc_rdata", 64'(readdata), 64'(m_rd));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic rd(input logic [2:0] a);
        read = 1'b1; address = a;
        @(posedge clock);
        @(negedge clock);
        read = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        write = 1'b1; address = a; writedata = d;
        @(posedge clock);
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic align_tick();
        int n = 0;
        while (!(m_en && m_pre == PRESCALE - 1) && n < 2 * PRESCALE + 2) begin
            idle(1);
            n++;
        end
        chk("align_tick", 64'(m_en && m_pre == PRESCALE - 1), 64'd1);
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        chk_on  = 1'b1;
        chk("reset_rdv", 64'(readdatavalid), 64'd0);
        chk("reset_rdata", 64'(readdata), 64'd0);

        rd(3'd0); chk("id", 64'(readdata), 64'hCAFE_0001);
        chk("id_rdv", 64'(readdatavalid), 64'd1);
        idle(1);  chk("rdv_one_cycle", 64'(readdatavalid), 64'd0);
        rd(3'd1); chk("timestamp", 64'(readdata), 64'd1563155245);
        rd(3'd2); chk("caps", 64'(readdata), 64'h0004_0030);

        wr(3'd3, 32'hA5A5_5A5A);
        rd(3'd3); chk("scratch", 64'(readdata), 64'hA5A5_5A5A);
        wr(3'd0, 32'hFFFF_FFFF);
        rd(3'd0); chk("id_ro", 64'(readdata), 64'hCAFE_0001);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7); chk("reserved", 64'(readdata), 64'd0);

        wr(3'd6, 32'h3);
        idle(40);
        rd(3'd4); chk("uptime_40", 64'(readdata), 64'd10);
        wr(3'd6, 32'h0);
        idle(20);
        rd(3'd4); chk("frozen_a", 64'(readdata), 64'd10);
        idle(3);
        rd(3'd4); chk("frozen_b", 64'(readdata), 64'd10);
        rd(3'd6); chk("ctrl_off", 64'(readdata), 64'd0);
        wr(3'd6, 32'h1);

        align_tick();
        force dut.u_ctr.r_count = 48'h0000_FFFF_FFFF;
        m_up = 48'h0000_FFFF_FFFF;
        #1 release dut.u_ctr.r_count;
        rd(3'd4); chk("lo_at_tick", 64'(readdata), 64'hFFFF_FFFF);
        rd(3'd5); chk("hi_at_tick", 64'(readdata), 64'd0);
        rd(3'd4); chk("lo_after", 64'(readdata), 64'd0);
        rd(3'd5); chk("hi_after", 64'(readdata), 64'd1);

        align_tick();
        force dut.u_ctr.r_count = 48'hFFFF_FFFF_FFFF;
        m_up = 48'hFFFF_FFFF_FFFF;
        #1 release dut.u_ctr.r_count;
        rd(3'd4); chk("lo_allones", 64'(readdata), 64'hFFFF_FFFF);
        rd(3'd5); chk("hi_allones", 64'(readdata), 64'h0000_FFFF);
        rd(3'd4); chk("lo_wrap", 64'(readdata), 64'd0);
        rd(3'd5); chk("hi_wrap", 64'(readdata), 64'd0);

        align_tick();
        wr(3'd6, 32'h3);
        rd(3'd4); chk("clr_vs_tick", 64'(readdata), 64'd0);
        rd(3'd6); chk("ctrl_en", 64'(readdata), 64'd1);

        read = 1'b1; write = 1'b1; address = 3'd3; writedata = 32'hDEAD_BEEF;
        @(posedge clock);
        @(negedge clock);
        read = 1'b0; write = 1'b0;
        chk("rw_old", 64'(readdata), 64'hA5A5_5A5A);
        rd(3'd3); chk("rw_new", 64'(readdata), 64'hDEAD_BEEF);

        read = 1'b1; address = 3'd3;
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1 chk("rst_rdv", 64'(readdatavalid), 64'd0);
        chk("rst_rdata", 64'(readdata), 64'd0);
        read = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        rd(3'd3); chk("rst_scratch", 64'(readdata), 64'(SCRATCH_RST));
        rd(3'd4); chk("rst_uptime", 64'(readdata), 64'd0);
        rd(3'd6); chk("rst_en", 64'(readdata), 64'd1);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sysid_uptime_slave.md
Name: sysid_uptime_slave

Overview:
- Parametrised successor to the fixed system-ID slave: an Avalon-MM control slave exposing the system ID, build timestamp, a capability word, a scratch register and a free-running uptime counter.
- Read data is registered: fixed read latency 1 with readdatavalid.
- Sits on the Qsys interconnect next to the CPU. Software uses it to identify the hardware build and to timestamp events.

Parameters:
- ID_VALUE, 32'h0000_0000, system ID returned at word 0
- TIMESTAMP, 32'd1563155245, build timestamp returned at word 1
- UPTIME_W, 64, uptime counter width (33..64); unused upper bits of UPTIME_HI read 0
- PRESCALE, 1, clock cycles per uptime tick (1..65535); 1 means tick every cycle
- SCRATCH_RST, 32'h0000_0000, reset value of SCRATCH

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word address
- read  in  1  read strobe
- write  in  1  write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- readdatavalid  out  1  high one cycle after an accepted read

Behaviour:
- Reset (async assert, sync deassert from upstream): readdata=0, readdatavalid=0, SCRATCH=SCRATCH_RST, uptime=0, prescaler=0, shadow=0, CTRL.EN=1.
- No waitrequest. Every read or write is accepted in the cycle it is presented.
- Register map (word addresses):
  - 0 ID: RO, ID_VALUE.
  - 1 TIMESTAMP: RO.
  - 2 CAPS: RO, [31:16]=PRESCALE, [7:0]=UPTIME_W.
  - 3 SCRATCH: RW.
  - 4 UPTIME_LO: RO, uptime[31:0]. The same read copies uptime[UPTIME_W-1:32] into the HI shadow.
  - 5 UPTIME_HI: RO, returns the shadow. It does not read the live counter.
  - 6 CTRL: bit0 EN is RW. bit1 CLR is write-1 pulse and reads 0. Other bits read 0.
  - 7 reserved: reads 0, writes ignored.
- Writes to RO or reserved words are ignored silently.
- Read timing: if read is high at edge N, readdata holds the addressed value sampled at edge N and readdatavalid=1 for exactly the following cycle. Otherwise readdatavalid=0 and readdata holds its last value.
- Read and write in the same cycle: both are performed. The read returns the pre-write value.
- Prescaler:
  - Counts 0..PRESCALE-1 while EN=1 and holds while EN=0.
  - A tick occurs when prescaler==PRESCALE-1 and EN=1. On a tick the prescaler goes to 0 and uptime increments.
  - PRESCALE=1 means a tick on every enabled cycle.
- Uptime wraps modulo 2^UPTIME_W. All-ones plus one gives 0, with no sticky flag.
- CLR (write CTRL with bit1=1):
  - Zeroes uptime and prescaler at that edge. CLR has priority over a simultaneous tick.
  - EN takes writedata[0] in the same write.
  - The shadow is untouched.
- UPTIME_LO read coinciding with a tick: LO and the shadow both sample the pre-increment value, so they stay consistent.
- UPTIME_LO read coinciding with CLR: returns the pre-clear value.
- Reset asserted mid-read: readdatavalid drops immediately (async). The pending read is lost.

Decomposition:
- Shared package sysid_pkg holds:
  - word-address constants ADDR_ID..ADDR_CTRL;
  - CTRL bit indices CTRL_EN=0, CTRL_CLR=1;
  - CAPS field positions.
- One natural sub-module, sysid_uptime_ctr, containing the prescaler, counter, EN and CLR. Its interface is en, clr, and count[UPTIME_W-1:0]. The top level holds the register decode, SCRATCH, the shadow and the read pipeline.

Test Plan:
- Reset, then read addresses 0, 1, 2 with ID_VALUE=32'hCAFE0001, PRESCALE=4, UPTIME_W=48.
  - Required: 32'hCAFE0001, 32'd1563155245, 32'h0004_0030.
  - Each arrives one cycle after read, with readdatavalid high exactly 1 cycle.
- Write SCRATCH=32'hA5A5_5A5A, then read back.
  - Required: 32'hA5A5_5A5A.
  - Also write address 0 with 32'hFFFF_FFFF; a later read of address 0 still returns ID_VALUE.
- PRESCALE=4, EN=1 after reset; read UPTIME_LO after 40 cycles.
  - Required: 10 (±1 per documented sampling edge).
  - Write CTRL=0 (EN off), wait 20 cycles; two LO reads return the same value.
- Force uptime to 48'h0000_FFFF_FFFF (PRESCALE=1) and read LO in the cycle it ticks.
  - Required: LO=32'hFFFF_FFFF and HI=0.
  - A subsequent LO/HI pair returns 32'h0000_0000 / 32'h0000_0001.
  - Uptime at all-ones wraps to 0.
- Write CTRL=32'h3 while a tick is due; the next LO read returns 0 or 1. Then:
  - read CTRL returns 32'h1;
  - simultaneous read+write of SCRATCH returns the old value.
- Assert reset_n low during a read cycle.
  - Required: readdatavalid=0 immediately, SCRATCH returns to SCRATCH_RST, uptime=0.
